// File: rtl/msf_encoder_pkg.sv
// Shared constants, state type and BCD field bundle for the MSF time-code encoder.
package msf_encoder_pkg;

   localparam int unsigned SLOTS_PER_SEC  = 10;
   localparam int unsigned SECS_PER_FRAME = 60;
   localparam int unsigned MARKER_SLOTS   = 5;
   localparam logic [7:0]  MARKER_PATTERN = 8'b0111_1110;

   localparam int unsigned YEAR_FIRST   = 17;
   localparam int unsigned YEAR_LAST    = 24;
   localparam int unsigned DATE_FIRST   = 25;
   localparam int unsigned DATE_LAST    = 35;
   localparam int unsigned DOW_FIRST    = 36;
   localparam int unsigned DOW_LAST     = 38;
   localparam int unsigned TIME_FIRST   = 39;
   localparam int unsigned TIME_LAST    = 51;
   localparam int unsigned MARKER_FIRST = 52;
   localparam int unsigned MARKER_LAST  = 59;

   localparam int unsigned PAR_YEAR_SEC = 54;
   localparam int unsigned PAR_DATE_SEC = 55;
   localparam int unsigned PAR_DOW_SEC  = 56;
   localparam int unsigned PAR_TIME_SEC = 57;

   localparam int unsigned FIELD_BITS = TIME_LAST - YEAR_FIRST + 1;

   typedef enum logic {StIdle, StTx} state_e;

   // Member order matches transmission order, so the packed vector's MSB is second 17.
   typedef struct packed {
      logic [3:0] year_h;
      logic [3:0] year_l;
      logic       month_h;
      logic [3:0] month_l;
      logic [1:0] day_h;
      logic [3:0] day_l;
      logic [2:0] dow;
      logic [1:0] hour_h;
      logic [3:0] hour_l;
      logic [2:0] minute_h;
      logic [3:0] minute_l;
   } msf_fields_t;

   // Bit that makes the A bits of seconds first..last plus itself odd in ones.
   function automatic logic odd_parity(input logic [FIELD_BITS-1:0] data,
                                       input int unsigned first, input int unsigned last);
      logic p;
      p = 1'b1;
      for (int unsigned s = YEAR_FIRST; s <= TIME_LAST; s++) begin
         if (s >= first && s <= last) p = p ^ data[TIME_LAST - s];
      end
      return p;
   endfunction

endpackage

// File: rtl/msf_frame_bits.sv
// Combinational map from second index and latched time fields to the A/B data bits.
module msf_frame_bits
   import msf_encoder_pkg::*;
(
   input  logic [5:0]  second,
   input  msf_fields_t fields,
   output logic        bit_a,
   output logic        bit_b
);

   logic [FIELD_BITS-1:0] data;
   logic [5:0]            data_off;
   logic [2:0]            mark_off;

   assign data = fields;

   always_comb begin
      bit_a    = 1'b0;
      bit_b    = 1'b0;
      data_off = 6'(TIME_LAST) - second;
      mark_off = 3'(6'(MARKER_LAST) - second);

      if (second >= 6'(YEAR_FIRST) && second <= 6'(TIME_LAST)) begin
         bit_a = data[data_off];
      end else if (second >= 6'(MARKER_FIRST)) begin
         bit_a = MARKER_PATTERN[mark_off];
      end

      case (second)
         6'(PAR_YEAR_SEC): bit_b = odd_parity(data, YEAR_FIRST, YEAR_LAST);
         6'(PAR_DATE_SEC): bit_b = odd_parity(data, DATE_FIRST, DATE_LAST);
         6'(PAR_DOW_SEC):  bit_b = odd_parity(data, DOW_FIRST, DOW_LAST);
         6'(PAR_TIME_SEC): bit_b = odd_parity(data, TIME_FIRST, TIME_LAST);
         default:          bit_b = 1'b0;
      endcase
   end

endmodule

// File: rtl/msf_encoder.sv
// MSF time-code frame generator: slot/second timing, IDLE/TX control and double-buffered
// time fields so a new minute can be queued while the current one is on air.
module msf_encoder
   import msf_encoder_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 12500
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [3:0] year_h_i,
   input  logic [3:0] year_l_i,
   input  logic       month_h_i,
   input  logic [3:0] month_l_i,
   input  logic [1:0] day_h_i,
   input  logic [3:0] day_l_i,
   input  logic [2:0] dow_i,
   input  logic [1:0] hour_h_i,
   input  logic [3:0] hour_l_i,
   input  logic [2:0] minute_h_i,
   input  logic [3:0] minute_l_i,
   output logic       msf_o,
   output logic [5:0] second_o,
   output logic       minute_start_o,
   output logic       busy_o
);

   localparam int unsigned SLOT_CYC = CLK_FREQ / 10;
   localparam int unsigned CW       = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [3:0]    slot_q, slot_d;
   logic [5:0]    sec_q, sec_d;
   msf_fields_t   active_q, active_d, shadow_q, shadow_d, in_fields;
   logic          pending_q, pending_d;
   logic          slot_end, sec_end, frame_end;
   logic          bit_a, bit_b, msf_d, minute_start_d;

   assign in_fields = '{year_h: year_h_i, year_l: year_l_i, month_h: month_h_i,
                        month_l: month_l_i, day_h: day_h_i, day_l: day_l_i, dow: dow_i,
                        hour_h: hour_h_i, hour_l: hour_l_i, minute_h: minute_h_i,
                        minute_l: minute_l_i};

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      slot_d    = slot_q;
      sec_d     = sec_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      slot_end  = cyc_q == CW'(SLOT_CYC - 1);
      sec_end   = slot_end && slot_q == 4'(SLOTS_PER_SEC - 1);
      frame_end = sec_end && sec_q == 6'(SECS_PER_FRAME - 1);

      case (state_q)
         StIdle: begin
            if (load_i) begin
               state_d  = StTx;
               active_d = in_fields;
            end
         end
         StTx: begin
            cyc_d  = slot_end ? '0 : cyc_q + 1'b1;
            slot_d = sec_end ? '0 : (slot_end ? slot_q + 4'd1 : slot_q);
            sec_d  = frame_end ? '0 : (sec_end ? sec_q + 6'd1 : sec_q);
            // A load on the frame's last cycle bypasses the shadow and wins outright.
            if (frame_end) begin
               pending_d = 1'b0;
               if (load_i)         active_d = in_fields;
               else if (pending_q) active_d = shadow_q;
            end else if (load_i) begin
               shadow_d  = in_fields;
               pending_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   msf_frame_bits u_frame_bits (
      .second (sec_d),
      .fields (active_d),
      .bit_a  (bit_a),
      .bit_b  (bit_b)
   );

   // Output level is decoded from next-state values so msf_o lines up with the counters.
   always_comb begin
      msf_d = 1'b0;
      if (state_d == StTx) begin
         if (sec_d == '0) begin
            msf_d = slot_d < 4'(MARKER_SLOTS);
         end else begin
            case (slot_d)
               4'd0:    msf_d = 1'b1;
               4'd1:    msf_d = bit_a;
               4'd2:    msf_d = bit_b;
               default: msf_d = 1'b0;
            endcase
         end
      end
      minute_start_d = state_d == StTx && sec_d == '0 && slot_d == '0 && cyc_d == '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         cyc_q          <= '0;
         slot_q         <= '0;
         sec_q          <= '0;
         active_q       <= '0;
         shadow_q       <= '0;
         pending_q      <= 1'b0;
         msf_o          <= 1'b0;
         minute_start_o <= 1'b0;
      end else begin
         state_q        <= state_d;
         cyc_q          <= cyc_d;
         slot_q         <= slot_d;
         sec_q          <= sec_d;
         active_q       <= active_d;
         shadow_q       <= shadow_d;
         pending_q      <= pending_d;
         msf_o          <= msf_d;
         minute_start_o <= minute_start_d;
      end
   end

   assign busy_o   = state_q == StTx;
   assign second_o = sec_q;

endmodule

// File: tb/tb_msf_encoder.sv
// Self-checking bench for msf_encoder at CLK_FREQ=100 against a table-driven frame model.
module tb_msf_encoder;

   localparam int unsigned CLK_FREQ = 100;
   localparam int          SLOT     = CLK_FREQ / 10;
   localparam int          FRAME    = 60 * 10 * SLOT;

   typedef struct packed {
      logic [3:0] yh;
      logic [3:0] yl;
      logic       mh;
      logic [3:0] ml;
      logic [1:0] dh;
      logic [3:0] dl;
      logic [2:0] dow;
      logic [1:0] hh;
      logic [3:0] hl;
      logic [2:0] nh;
      logic [3:0] nl;
   } tf_t;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       load_i = 1'b0;
   logic [3:0] year_h = '0, year_l = '0, month_l = '0, day_l = '0, hour_l = '0, minute_l = '0;
   logic       month_h = 1'b0;
   logic [1:0] day_h = '0, hour_h = '0;
   logic [2:0] dow = '0, minute_h = '0;
   logic       msf_o, minute_start_o, busy_o;
   logic [5:0] second_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   bit   exp_a[60];
   bit   exp_b[60];
   logic obs_a[60];
   logic obs_b[60];

   int w_year[8]   = '{80, 40, 20, 10, 8, 4, 2, 1};
   int w_month[5]  = '{10, 8, 4, 2, 1};
   int w_day[6]    = '{20, 10, 8, 4, 2, 1};
   int w_dow[3]    = '{4, 2, 1};
   int w_hour[6]   = '{20, 10, 8, 4, 2, 1};
   int w_minute[7] = '{40, 20, 10, 8, 4, 2, 1};

   always #5 clk = ~clk;

   msf_encoder #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .load_i         (load_i),
      .year_h_i       (year_h),
      .year_l_i       (year_l),
      .month_h_i      (month_h),
      .month_l_i      (month_l),
      .day_h_i        (day_h),
      .day_l_i        (day_l),
      .dow_i          (dow),
      .hour_h_i       (hour_h),
      .hour_l_i       (hour_l),
      .minute_h_i     (minute_h),
      .minute_l_i     (minute_l),
      .msf_o          (msf_o),
      .second_o       (second_o),
      .minute_start_o (minute_start_o),
      .busy_o         (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic tf_t mk(input int yh, input int yl, input int mh, input int ml,
                              input int dh, input int dl, input int dw, input int hh,
                              input int hl, input int nh, input int nl);
      tf_t r;
      r.yh = 4'(yh); r.yl = 4'(yl); r.mh = 1'(mh); r.ml = 4'(ml);
      r.dh = 2'(dh); r.dl = 4'(dl); r.dow = 3'(dw); r.hh = 2'(hh);
      r.hl = 4'(hl); r.nh = 3'(nh); r.nl = 4'(nl);
      return r;
   endfunction

   function automatic tf_t rand_fields();
      return mk(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)),
                int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(15)),
                int'($urandom_range(7)), int'($urandom_range(3)), int'($urandom_range(15)),
                int'($urandom_range(7)), int'($urandom_range(15)));
   endfunction

   task automatic drive(input tf_t f);
      year_h = f.yh; year_l = f.yl; month_h = f.mh; month_l = f.ml; day_h = f.dh;
      day_l = f.dl; dow = f.dow; hour_h = f.hh; hour_l = f.hl; minute_h = f.nh;
      minute_l = f.nl;
   endtask

   // Value of the bit weighted w in a two-digit BCD number (tens digit h, units digit l).
   function automatic bit bcd_bit(input int h, input int l, input int w);
      if (w >= 10) return ((h / (w / 10)) % 2) == 1;
      return ((l / w) % 2) == 1;
   endfunction

   function automatic bit odd_fill(input int lo, input int hi);
      int ones = 0;
      for (int s = lo; s <= hi; s++) ones += int'(exp_a[s]);
      return (ones % 2) == 0;
   endfunction

   task automatic build_model(input tf_t f);
      int s;
      for (int i = 0; i < 60; i++) begin
         exp_a[i] = 1'b0;
         exp_b[i] = 1'b0;
      end
      s = 17;
      foreach (w_year[i])   begin exp_a[s] = bcd_bit(f.yh, f.yl, w_year[i]); s++; end
      foreach (w_month[i])  begin exp_a[s] = bcd_bit(f.mh, f.ml, w_month[i]); s++; end
      foreach (w_day[i])    begin exp_a[s] = bcd_bit(f.dh, f.dl, w_day[i]); s++; end
      foreach (w_dow[i])    begin exp_a[s] = bcd_bit(0, f.dow, w_dow[i]); s++; end
      foreach (w_hour[i])   begin exp_a[s] = bcd_bit(f.hh, f.hl, w_hour[i]); s++; end
      foreach (w_minute[i]) begin exp_a[s] = bcd_bit(f.nh, f.nl, w_minute[i]); s++; end
      for (int i = 52; i < 60; i++) exp_a[i] = (i > 52 && i < 59);
      exp_b[54] = odd_fill(17, 24);
      exp_b[55] = odd_fill(25, 35);
      exp_b[56] = odd_fill(36, 38);
      exp_b[57] = odd_fill(39, 51);
   endtask

   function automatic bit exp_level(input int sec, input int slot);
      if (sec == 0) return slot < 5;
      if (slot == 0) return 1'b1;
      if (slot == 1) return exp_a[sec];
      if (slot == 2) return exp_b[sec];
      return 1'b0;
   endfunction

   function automatic logic [63:0] pack(input bit use_b, input int lo, input int hi);
      logic [63:0] r = '0;
      for (int s = lo; s <= hi; s++) r = {r[62:0], use_b ? obs_b[s] : obs_a[s]};
      return r;
   endfunction

   task automatic check_idle(input string tag);
      check(tag, {msf_o, busy_o, minute_start_o, second_o}, 64'd0);
   endtask

   // Entered at the first sampled cycle of a frame; leaves at the first cycle of the next
   // (or at cycle index stop_at). Loads are applied so the edge ending cycle l*_at sees them.
   task automatic run_frame(input string tag, input tf_t f, input int stop_at,
                            input int l1_at, input tf_t l1, input int l2_at, input tf_t l2);
      int ms_cnt = 0;
      int hi0    = 0;
      int idx;
      build_model(f);
      for (int sec = 0; sec < 60; sec++) begin
         for (int slot = 0; slot < 10; slot++) begin
            logic [SLOT-1:0] v_msf, v_ms, v_busy, e_msf, e_ms;
            logic [5:0]      sec_first, sec_last;
            v_msf = '0; v_ms = '0; v_busy = '0; sec_first = '0; sec_last = '0;
            for (int c = 0; c < SLOT; c++) begin
               idx = (sec * 10 + slot) * SLOT + c;
               if (idx == stop_at) begin
                  load_i = 1'b0;
                  return;
               end
               v_msf[c] = msf_o; v_ms[c] = minute_start_o; v_busy[c] = busy_o;
               if (c == 0) sec_first = second_o;
               if (c == SLOT - 1) sec_last = second_o;
               if (sec == 0 && msf_o === 1'b1) hi0++;
               if (minute_start_o === 1'b1) ms_cnt++;
               if (slot == 1 && c == 0) obs_a[sec] = msf_o;
               if (slot == 2 && c == 0) obs_b[sec] = msf_o;
               load_i = 1'b0;
               if (idx == l1_at) begin drive(l1); load_i = 1'b1; end
               if (idx == l2_at) begin drive(l2); load_i = 1'b1; end
               @(negedge clk);
            end
            e_msf = exp_level(sec, slot) ? {SLOT{1'b1}} : '0;
            e_ms  = (sec == 0 && slot == 0) ? SLOT'(1) : '0;
            check($sformatf("%s s%0d.%0d msf", tag, sec, slot), 64'(v_msf), 64'(e_msf));
            check($sformatf("%s s%0d.%0d ctl", tag, sec, slot),
                  64'({v_ms, v_busy, sec_first, sec_last}),
                  64'({e_ms, {SLOT{1'b1}}, 6'(sec), 6'(sec)}));
         end
      end
      load_i = 1'b0;
      check({tag, " marker high cycles"}, 64'(hi0), 64'(5 * SLOT));
      check({tag, " minute_start pulses"}, 64'(ms_cnt), 64'd1);
   endtask

   initial begin
      tf_t d1, d2, r1, r2, r3, r4, r5, none;
      d1   = mk(2, 3, 0, 4, 1, 5, 6, 1, 2, 3, 4);
      d2   = mk(2, 4, 1, 2, 3, 1, 2, 2, 3, 5, 9);
      none = '0;
      r1 = rand_fields(); r2 = rand_fields(); r3 = rand_fields();
      r4 = rand_fields(); r5 = rand_fields();

      // Reset for two cycles, with a load on the second one that must be ignored.
      @(negedge clk);
      drive(d2);
      load_i = 1'b1;
      @(negedge clk);
      rst_i  = 1'b0;
      load_i = 1'b0;
      check_idle("reset");
      repeat (5) @(negedge clk);
      check_idle("idle hold");

      // Directed minute, with the 2024 minute queued at second 30.
      drive(d1);
      load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      check("first cycle", {msf_o, minute_start_o, busy_o}, 3'b111);
      run_frame("f1", d1, -1, 30 * 10 * SLOT, d2, -1, none);
      check("f1 A17-24", pack(0, 17, 24), 64'b00100011);
      check("f1 A39-51", pack(0, 39, 51), 64'b0100100110100);
      check("f1 B54-57", pack(1, 54, 57), 64'b0110);
      check("f1 B1-53 zero", pack(1, 1, 53), 64'd0);
      check("f1 B58-59 zero", pack(1, 58, 59), 64'd0);
      check("f1 A52-59", pack(0, 52, 59), 64'b01111110);
      check("f1 A1-16 zero", pack(0, 1, 16), 64'd0);

      // Queued minute follows with no gap; a mid-frame load is then overridden by one on
      // the frame's last cycle.
      run_frame("f2", d2, -1, 20 * 10 * SLOT, r1, FRAME - 1, r2);
      check("f2 A17-24", pack(0, 17, 24), 64'b00100100);

      // Two shadow loads in one frame: the later one is used.
      run_frame("f3", r2, -1, 10 * 10 * SLOT + 3, r3, 45 * 10 * SLOT + 7, r4);
      run_frame("f4", r4, -1, -1, none, -1, none);
      run_frame("f5", r4, (40 * 10 + 1) * SLOT, -1, none, -1, none);

      // Mid-frame reset with a coincident load.
      drive(r1);
      rst_i  = 1'b1;
      load_i = 1'b1;
      @(negedge clk);
      rst_i  = 1'b0;
      load_i = 1'b0;
      check_idle("mid-frame reset");
      repeat (3) @(negedge clk);
      check_idle("post-reset idle");

      drive(r5);
      load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      run_frame("f6", r5, -1, -1, none, -1, none);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
